// File: rtl/led_pkg.sv
// Shared encodings for the LED blink generator: command modes and FSM states.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package led_pkg;

  // Command mode encoding carried on cmd_mode
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  // FSM state encoding; deliberately equal to the mode encoding so an
  // accepted command can load the state register directly from cmd_mode.
  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_ON    = 2'd1;
  localparam logic [1:0] S_BLINK = 2'd2;
  localparam logic [1:0] S_BURST = 2'd3;

  // LED level right after a command is accepted. BLINK and BURST start in
  // their on-phase; a zero-length BURST is handled separately by the caller.
  function automatic logic mode_led(input logic [1:0] mode);
    return (mode != MODE_OFF);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and flags the last count as a one-cycle tick.
// Latency: tick is combinational from the count register (asserted while count == TICK_DIV-1).
// Backpressure: none; free-running, clr restarts the count from 0 on the next edge.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;

  assign tick = (pre == LAST);

  // Count up, wrap after the tick cycle, restart on reset or phase-align clear
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/led_blink_gen.sv
// LED pattern generator: OFF / ON / free-running BLINK / counted BURST driven by a command port.
// Latency: led follows an accepted command on the next cycle; done/busy are decoded from registered state.
// Backpressure: cmd_ready = !busy, so commands stall only while a BURST is running.
module led_blink_gen #(
  parameter int TICK_DIV = 50000,
  parameter int HALF_W   = 16,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [HALF_W-1:0] cmd_half,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              led,
  output logic              busy,
  output logic              done
);

  import led_pkg::*;

  logic [1:0]        state;
  logic [HALF_W-1:0] half_q;     // latched half-period, already forced to >= 1
  logic [HALF_W-1:0] half_cnt;   // ticks elapsed in the current phase
  logic [CNT_W-1:0]  count_q;    // latched burst length in full periods
  logic [CNT_W-1:0]  burst_cnt;  // full periods completed so far

  logic tick;
  logic accept;
  logic half_wrap;
  logic period_end;
  logic burst_last;

  // Prescaler is cleared on accept so the first phase is exactly half ticks long
  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .tick(tick)
  );

  assign accept = cmd_valid & cmd_ready;

  // Last tick of the current phase
  assign half_wrap = tick && (half_cnt == (half_q - 1'b1));

  // A period is complete when an off-phase ends
  assign period_end = half_wrap && !led;

  // The burst ends on the tick closing its final off-phase, or straight away
  // when it was started with a zero count. done and busy are decoded in that
  // same cycle, so the done cycle is also the first cycle with busy low.
  assign burst_last = (state == S_BURST) &&
                      ((count_q == '0) ||
                       (period_end && (burst_cnt == (count_q - 1'b1))));

  // A reset arriving in the final burst cycle aborts it silently
  assign done      = burst_last & ~rst;
  assign busy      = (state == S_BURST) & ~burst_last;
  assign cmd_ready = ~busy;

  // Mode FSM, LED register and the half/burst counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_OFF;
      led       <= 1'b0;
      half_q    <= '0;
      half_cnt  <= '0;
      count_q   <= '0;
      burst_cnt <= '0;
    end else if (accept) begin
      // New command replaces whatever mode is running and restarts the phase
      state     <= cmd_mode;
      half_q    <= (cmd_half == '0) ? HALF_W'(1) : cmd_half;
      count_q   <= cmd_count;
      half_cnt  <= '0;
      burst_cnt <= '0;
      led       <= mode_led(cmd_mode) &&
                   !((cmd_mode == MODE_BURST) && (cmd_count == '0));
    end else begin
      case (state)
        S_BLINK: begin
          if (half_wrap) begin
            half_cnt <= '0;
            led      <= ~led;
          end else if (tick) begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        S_BURST: begin
          if (burst_last) begin
            state     <= S_OFF;
            led       <= 1'b0;
            half_cnt  <= '0;
            burst_cnt <= '0;
          end else if (half_wrap) begin
            half_cnt <= '0;
            led      <= ~led;
            if (!led) begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end else if (tick) begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: begin
          // S_OFF / S_ON: led is static, phase counter parked at zero
          half_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_gen.sv
// Directed bench for led_blink_gen with TICK_DIV=4.
// Cycle k means the k-th cycle after the accept edge; outputs are sampled on the falling edge.
// Inputs are driven away from the rising edge.
module tb_led_blink_gen;

  import led_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [15:0] cmd_half;
  logic [7:0]  cmd_count;
  logic        led;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  led_blink_gen #(
    .TICK_DIV(4),
    .HALF_W  (16),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mode (cmd_mode),
    .cmd_half (cmd_half),
    .cmd_count(cmd_count),
    .led      (led),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one command for exactly one rising edge; returns just after that edge
  task automatic issue(input logic [1:0] m, input logic [15:0] h, input logic [7:0] c);
    @(negedge clk);
    cmd_mode  = m;
    cmd_half  = h;
    cmd_count = c;
    cmd_valid = 1'b1;
    check_eq("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_led;
    logic exp_busy;
    logic exp_done;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = MODE_OFF;
    cmd_half  = '0;
    cmd_count = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_led",   {31'd0, led},       32'd0);
    check_eq("rst_busy",  {31'd0, busy},      32'd0);
    check_eq("rst_done",  {31'd0, done},      32'd0);
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // A command presented together with reset is dropped
    cmd_mode  = MODE_ON;
    cmd_half  = 16'd1;
    cmd_valid = 1'b1;
    @(negedge clk);
    check_eq("rst_prio_led",   {31'd0, led},       32'd0);
    check_eq("rst_prio_state", {30'd0, dut.state}, {30'd0, S_OFF});
    cmd_valid = 1'b0;
    rst       = 1'b0;

    // Idle for 100 cycles with no command
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      check_eq($sformatf("idle c%0d {led,busy,done,rdy}", k),
               {28'd0, led, busy, done, cmd_ready}, 32'b0001);
    end

    // BLINK half=2: 8 cycles on, 8 off, for 5 periods
    issue(MODE_BLINK, 16'd2, 8'd0);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      exp_led = (((k - 1) / 8) % 2) == 0;
      check_eq($sformatf("blink2 c%0d {led,busy,done}", k),
               {29'd0, led, busy, done}, {29'd0, exp_led, 2'b00});
    end

    // BURST half=1 count=3, with a competing ON command held during the burst
    issue(MODE_BURST, 16'd1, 8'd3);
    cmd_mode  = MODE_ON;
    cmd_half  = 16'd1;
    cmd_valid = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      exp_led  = (k <= 24) && ((((k - 1) / 4) % 2) == 0);
      exp_busy = (k <= 23);
      exp_done = (k == 24);
      check_eq($sformatf("burst3 c%0d {led,busy,done,rdy}", k),
               {28'd0, led, busy, done, cmd_ready},
               {28'd0, exp_led, exp_busy, exp_done, ~exp_busy});
      if (k == 20) cmd_valid = 1'b0;
    end

    // BURST count=0: immediate done, never busy, led stays low
    issue(MODE_BURST, 16'd1, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_done = (k == 1);
      check_eq($sformatf("burst0 c%0d {led,busy,done,rdy}", k),
               {28'd0, led, busy, done, cmd_ready},
               {28'd0, 1'b0, 1'b0, exp_done, 1'b1});
    end

    // BLINK half=0 behaves as half=1: toggles every 4 cycles
    issue(MODE_BLINK, 16'd0, 8'd0);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      exp_led = (((k - 1) / 4) % 2) == 0;
      check_eq($sformatf("blink0 c%0d {led,busy,done}", k),
               {29'd0, led, busy, done}, {29'd0, exp_led, 2'b00});
    end

    // BURST count=5 aborted by reset at cycle 10
    issue(MODE_BURST, 16'd1, 8'd5);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_led = (((k - 1) / 4) % 2) == 0;
      check_eq($sformatf("burst5 c%0d {led,busy,done}", k),
               {29'd0, led, busy, done}, {29'd0, exp_led, 2'b10});
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort {led,busy,done,rdy}", {28'd0, led, busy, done, cmd_ready}, 32'b0001);
    check_eq("abort_state", {30'd0, dut.state}, {30'd0, S_OFF});
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("post_abort c%0d done", k), {31'd0, done}, 32'd0);
    end

    // ON after the abort: accepted, led high from the next cycle
    issue(MODE_ON, 16'd3, 8'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check_eq($sformatf("on c%0d {led,busy,done,rdy}", k),
               {28'd0, led, busy, done, cmd_ready}, 32'b1001);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_blink_gen.md
LED_BLINK_GEN -- requirements
Module: led_blink_gen

Interface
REQ-001 Parameter TICK_DIV, default 50000, SHALL set the clock cycles per tick (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter HALF_W, default 16, SHALL set the width of the half-period field in ticks.
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the burst-count field.
REQ-004 clk  input  1  SHALL be the single clock for all state; there is exactly one clock.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 cmd_valid  input  1  SHALL indicate that a command is presented.
REQ-007 cmd_ready  output  1  SHALL indicate that the block can accept a command.
REQ-008 cmd_mode  input  2  SHALL select the mode: 0 OFF, 1 ON, 2 BLINK, 3 BURST.
REQ-009 cmd_half  input  HALF_W  SHALL give the half-period in ticks; the value 0 SHALL be treated as 1.
REQ-010 cmd_count  input  CNT_W  SHALL give the number of full blink periods for BURST.
REQ-011 led  output  1  SHALL be the active-high LED drive, registered; it feeds the downstream inverter stage that produces the active-low pin.
REQ-012 busy  output  1  SHALL be high while a BURST is in progress.
REQ-013 done  output  1  SHALL be a one-cycle pulse at the end of a BURST.

Function
REQ-014 A command SHALL be accepted on any clk edge where cmd_valid and cmd_ready are both high; cmd_mode, cmd_half and cmd_count SHALL be latched at that edge.
REQ-015 cmd_ready SHALL equal NOT busy, so a command is accepted in the OFF, ON and BLINK states and is not accepted during BURST.
REQ-016 The FSM SHALL have the states S_OFF, S_ON, S_BLINK and S_BURST; an accepted command SHALL move the FSM to the state named by cmd_mode, replacing any current mode.
REQ-017 On accept, the tick prescaler and the half-period counter SHALL clear, so that the blink phase is aligned to the accept edge.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 and SHALL assert an internal tick for one cycle when it reaches TICK_DIV-1, then wrap to 0.
REQ-019 led SHALL take the value of the new mode on the cycle after accept: S_OFF gives 0, S_ON gives 1, S_BLINK and S_BURST give 1 (on-phase first).
REQ-020 In S_BLINK and S_BURST, on the tick where the half counter equals half-1, led SHALL toggle and the half counter SHALL clear; otherwise the half counter SHALL increment on each tick.
REQ-021 In S_BLINK, led SHALL therefore toggle every half*TICK_DIV cycles, indefinitely.
REQ-022 In S_BURST, one period SHALL be counted at the end of each off-phase.
REQ-023 When the count-th off-phase ends, the block SHALL go to S_OFF, hold led at 0, pulse done high for that one cycle, and drop busy in the same cycle.
REQ-024 A BURST with cmd_count 0 SHALL pulse done on the cycle after accept, hold led at 0 and enter S_OFF without emitting any on-phase.
REQ-025 busy SHALL rise on the cycle after a BURST is accepted and SHALL fall in the same cycle that done is high.
REQ-026 In S_OFF and S_ON the prescaler SHALL free-run and the half counter SHALL hold at 0.
REQ-027 The half-period and burst counters SHALL be exactly HALF_W and CNT_W bits wide, so the maximum values are usable without overflow.

Reset
REQ-028 On rst high at a clk edge, the block SHALL enter S_OFF with led 0, busy 0, done 0, cmd_ready 1, and all counters and latched fields 0.
REQ-029 If rst is asserted and a command is valid at the same edge, rst SHALL take priority and the command SHALL be dropped.
REQ-030 A rst during BURST SHALL abort the burst with no done pulse.

Structure
REQ-031 A shared package led_pkg SHALL hold the mode encoding constants MODE_OFF, MODE_ON, MODE_BLINK and MODE_BURST, and the FSM state encodings.
REQ-032 The prescaler SHALL be a separate sub-module tick_gen with ports clk, rst, clr and tick, parameterised by TICK_DIV.
REQ-033 All other logic, including the FSM and the half and burst counters, SHALL reside in led_blink_gen.

Verification (bench uses TICK_DIV=4)
REQ-034 After reset release with no command: led 0, busy 0, done 0 and cmd_ready 1 for 100 cycles.
REQ-035 Accept BLINK with half=2: led is 1 on the next cycle, then toggles every 8 cycles (1 for 8 cycles, 0 for 8 cycles), repeating for at least 5 periods.
REQ-036 Accept BURST with half=1 and count=3: led shows 3 periods of 4 cycles on and 4 cycles off; done pulses once on cycle 24 after accept; busy is high for cycles 1..23; cmd_valid held high during the burst is not accepted.
REQ-037 Accept BURST with count=0: done pulses on the cycle after accept, led stays 0, and busy never rises.
REQ-038 Accept BLINK with half=0: behaves exactly as half=1, with led toggling every 4 cycles.
REQ-039 Pulse rst at cycle 10 of a BURST with count=5: led is 0 and the FSM is in S_OFF on the next cycle; done is never asserted; a subsequent ON command is accepted and gives led 1 on the next cycle.
